// File: rtl/i2c_pkg.sv
// Shared I2C definitions: transaction FSM states, ACK/NACK line levels and
// the data_clk divider used by the bus-clock generator and its consumers.
// No logic; no latency; no flow control.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR,
        SLV_ACK1,
        WR,
        RD,
        SLV_ACK2,
        MSTR_ACK,
        STOP
    } i2c_state_t;

    // SDA level seen in the acknowledge slot
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    // core clk cycles per data_clk half period
    localparam int DIVIDER = 4;

endpackage

// File: rtl/i2c_master_txn_if.sv
// Bundle of the transaction request/response and SDA/SCL-control signals
// between the I2C master FSM and its user / pad side.
// master: FSM view; slave: requester + pad view. No latency; no backpressure.
interface i2c_master_txn_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
);
    logic              data_clk;      // phase from the clock generator
    logic              ena;           // request / continue a transaction
    logic [ADDR_W-1:0] addr;          // slave address
    logic              rw;            // 0 = write, 1 = read
    logic [DATA_W-1:0] data_wr;       // byte to write
    logic              sda_in;        // sampled SDA line
    logic              sda_pull_low;  // 1 = drive SDA low
    logic              scl_ena;       // 1 = pad SCL follows generator SCL
    logic              busy;          // transaction in progress
    logic [DATA_W-1:0] data_rd;       // last byte read
    logic              rd_valid;      // one-cycle pulse on data_rd update
    logic              ack_error;     // slave NACK seen

    modport master (
        input  data_clk, ena, addr, rw, data_wr, sda_in,
        output sda_pull_low, scl_ena, busy, data_rd, rd_valid, ack_error
    );

    modport slave (
        output data_clk, ena, addr, rw, data_wr, sda_in,
        input  sda_pull_low, scl_ena, busy, data_rd, rd_valid, ack_error
    );
endinterface

// File: rtl/i2c_edge_detect.sv
// Rise/fall detector for the generator's data_clk phase signal.
// Latency: rise/fall are combinational against a one-cycle delayed copy.
// No backpressure. Ports: clk, rst, data_clk in; rise, fall out.
module i2c_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic data_clk,
    output logic rise,
    output logic fall
);
    logic d_q;

    // Reset to 1 so a data_clk that is already high after reset is not
    // mistaken for a rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q <= 1'b1;
        end else begin
            d_q <= data_clk;
        end
    end

    assign rise = data_clk & ~d_q;
    assign fall = ~data_clk & d_q;
endmodule

// File: rtl/i2c_master_txn.sv
// Byte-level I2C master: START, address+R/W, data bytes with ACK handling, STOP.
// Latency: START driven the cycle after the first data_clk rise with ena high.
// Flow: ena/addr/rw/data_wr only evaluated at IDLE and ack boundaries.
// Ports: clk, rst (sync, active-high), bus (master modport).
module i2c_master_txn
    import i2c_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    i2c_master_txn_if.master  bus
);
    localparam int AW1   = ADDR_W + 1;
    localparam int MAXW  = (AW1 > DATA_W) ? AW1 : DATA_W;
    localparam int CNT_W = $clog2(MAXW + 1);
    localparam int AIW   = $clog2(AW1);
    localparam int DIW   = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] CNT_A   = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] CNT_D   = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_DM1 = CNT_W'(DATA_W - 1);

    logic rise;
    logic fall;

    i2c_edge_detect u_edge (
        .clk      (clk),
        .rst      (rst),
        .data_clk (bus.data_clk),
        .rise     (rise),
        .fall     (fall)
    );

    i2c_state_t        state_q, state_d;
    logic              sda_q, sda_d;
    logic              scl_q, scl_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] data_rd_q, data_rd_d;
    logic              rd_valid_q, rd_valid_d;
    logic              ack_err_q, ack_err_d;
    logic              ack_sent_q, ack_sent_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [ADDR_W:0]   addr_rw_q, addr_rw_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;

    logic [ADDR_W:0]   req_addr_rw;
    logic              same_req;
    logic [CNT_W-1:0]  cnt_dec;

    assign req_addr_rw = {bus.addr, bus.rw};
    // Continuation is only allowed for the same slave and direction;
    // anything else ends the transaction with a STOP.
    assign same_req    = bus.ena && (req_addr_rw == addr_rw_q);
    assign cnt_dec     = bit_cnt_q - 1'b1;

    always_comb begin
        state_d    = state_q;
        sda_d      = sda_q;
        scl_d      = scl_q;
        busy_d     = busy_q;
        data_rd_d  = data_rd_q;
        rd_valid_d = 1'b0;
        ack_err_d  = ack_err_q;
        ack_sent_d = ack_sent_q;
        bit_cnt_d  = bit_cnt_q;
        addr_rw_d  = addr_rw_q;
        tx_d       = tx_q;
        rx_d       = rx_q;

        unique case (state_q)
            IDLE: begin
                if (rise && bus.ena) begin
                    addr_rw_d = req_addr_rw;
                    tx_d      = bus.data_wr;
                    busy_d    = 1'b1;
                    ack_err_d = 1'b0;
                    sda_d     = 1'b1;    // SCL still released high: START
                    state_d   = START;
                end
            end
            START: begin
                if (fall) scl_d = 1'b1;
                if (rise) begin
                    sda_d     = ~addr_rw_q[ADDR_W];
                    bit_cnt_d = CNT_A;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                // bit_cnt holds the index of the bit currently on the bus
                if (rise) begin
                    if (bit_cnt_q == '0) begin
                        sda_d   = 1'b0;
                        state_d = SLV_ACK1;
                    end else begin
                        bit_cnt_d = cnt_dec;
                        sda_d     = ~addr_rw_q[AIW'(cnt_dec)];
                    end
                end
            end
            SLV_ACK1: begin
                if (fall && bus.sda_in == NACK) ack_err_d = 1'b1;
                if (rise) begin
                    if (ack_err_q) begin
                        sda_d   = 1'b1;
                        state_d = STOP;
                    end else if (!addr_rw_q[0]) begin
                        sda_d     = ~tx_q[DATA_W-1];
                        bit_cnt_d = CNT_DM1;
                        state_d   = WR;
                    end else begin
                        sda_d     = 1'b0;
                        bit_cnt_d = CNT_D;
                        state_d   = RD;
                    end
                end
            end
            WR: begin
                if (rise) begin
                    if (bit_cnt_q == '0) begin
                        sda_d   = 1'b0;
                        state_d = SLV_ACK2;
                    end else begin
                        bit_cnt_d = cnt_dec;
                        sda_d     = ~tx_q[DIW'(cnt_dec)];
                    end
                end
            end
            SLV_ACK2: begin
                if (fall && bus.sda_in == NACK) ack_err_d = 1'b1;
                if (rise) begin
                    if (!ack_err_q && same_req) begin
                        tx_d      = bus.data_wr;
                        sda_d     = ~bus.data_wr[DATA_W-1];
                        bit_cnt_d = CNT_DM1;
                        state_d   = WR;
                    end else begin
                        sda_d   = 1'b1;
                        state_d = STOP;
                    end
                end
            end
            RD: begin
                // bit_cnt holds the number of samples still to take
                if (fall && bit_cnt_q != '0) begin
                    rx_d      = {rx_q[DATA_W-2:0], bus.sda_in};
                    bit_cnt_d = cnt_dec;
                end
                if (rise && bit_cnt_q == '0) begin
                    data_rd_d  = rx_q;
                    rd_valid_d = 1'b1;
                    ack_sent_d = same_req;
                    sda_d      = same_req;   // pull low = ACK, release = NACK
                    state_d    = MSTR_ACK;
                end
            end
            MSTR_ACK: begin
                if (rise) begin
                    if (ack_sent_q) begin
                        sda_d     = 1'b0;
                        bit_cnt_d = CNT_D;
                        state_d   = RD;
                    end else begin
                        sda_d   = 1'b1;
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                // SCL is parked high mid-high, then SDA released: STOP
                if (fall) scl_d = 1'b0;
                if (rise) begin
                    sda_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sda_q      <= 1'b0;
            scl_q      <= 1'b0;
            busy_q     <= 1'b0;
            data_rd_q  <= '0;
            rd_valid_q <= 1'b0;
            ack_err_q  <= 1'b0;
            ack_sent_q <= 1'b0;
            bit_cnt_q  <= '0;
            addr_rw_q  <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
        end else begin
            state_q    <= state_d;
            sda_q      <= sda_d;
            scl_q      <= scl_d;
            busy_q     <= busy_d;
            data_rd_q  <= data_rd_d;
            rd_valid_q <= rd_valid_d;
            ack_err_q  <= ack_err_d;
            ack_sent_q <= ack_sent_d;
            bit_cnt_q  <= bit_cnt_d;
            addr_rw_q  <= addr_rw_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
        end
    end

    assign bus.sda_pull_low = sda_q;
    assign bus.scl_ena      = scl_q;
    assign bus.busy         = busy_q;
    assign bus.data_rd      = data_rd_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.ack_error    = ack_err_q;
endmodule

// File: tb/tb_i2c_master_txn.sv
// Bench for i2c_master_txn: data_clk generator, delayed generator SCL,
// scripted open-drain slave and a bus monitor logging SDA at mid-SCL-high.
// Directed scenarios with hand-computed bit streams.
module tb_i2c_master_txn;
    import i2c_pkg::*;

    localparam int AW = 7;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2c_master_txn_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    i2c_master_txn #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // data_clk: toggles every DIVIDER clk cycles while running
    logic dclk_run = 1'b1;
    int   dcnt = 0;
    logic data_clk_r = 1'b0;
    always @(posedge clk) begin
        if (dclk_run) begin
            if (dcnt == DIVIDER - 1) begin
                dcnt       <= 0;
                data_clk_r <= ~data_clk_r;
            end else begin
                dcnt <= dcnt + 1;
            end
        end
    end
    assign bus.data_clk = data_clk_r;

    // generator SCL lags data_clk by a quarter period
    logic [1:0] dly = 2'b00;
    always @(posedge clk) dly <= {dly[0], data_clk_r};
    logic pad_scl;
    assign pad_scl = bus.scl_ena ? dly[1] : 1'b1;

    // open-drain bus
    logic slv_pull = 1'b0;
    logic sda_line;
    assign sda_line   = ~(bus.sda_pull_low | slv_pull);
    assign bus.sda_in = sda_line;

    logic s_rise, s_fall;
    i2c_edge_detect u_sed (
        .clk      (clk),
        .rst      (rst),
        .data_clk (data_clk_r),
        .rise     (s_rise),
        .fall     (s_fall)
    );

    // slave script: slv_script[k] is the pull level applied at the k-th
    // data_clk rise after START (rise 0 is the START edge itself)
    logic        slv_script [64];
    logic        clr = 1'b0;
    int          rcnt = 0;
    int          starts = 0, stops = 0, nbits = 0, rdv = 0;
    logic [63:0] blog = '0;
    logic        sda_prev = 1'b1, scl_prev = 1'b1;

    always @(posedge clk) begin
        sda_prev <= sda_line;
        scl_prev <= pad_scl;
        if (clr || rst) begin
            starts <= 0; stops <= 0; nbits <= 0; rdv <= 0;
            blog <= '0; rcnt <= 0; slv_pull <= 1'b0;
        end else begin
            if (pad_scl && scl_prev && sda_prev && !sda_line) begin
                starts <= starts + 1;
                rcnt   <= 1;
            end else if (s_rise && rcnt != 0 && rcnt < 64) begin
                slv_pull <= slv_script[rcnt[5:0]];
                rcnt     <= rcnt + 1;
            end
            if (pad_scl && scl_prev && !sda_prev && sda_line) stops <= stops + 1;
            if (s_fall && bus.scl_ena) begin
                blog  <= {blog[62:0], sda_line};
                nbits <= nbits + 1;
            end
            if (bus.rd_valid) rdv <= rdv + 1;
        end
    end

    task automatic clear_script();
        for (int i = 0; i < 64; i++) slv_script[i] = 1'b0;
    endtask

    task automatic clear_mon();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic wait_busy(input logic lvl, input string tag);
        int n = 0;
        while (bus.busy !== lvl && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(bus.busy), 64'(lvl));
    endtask

    task automatic wait_rcnt(input int v, input string tag);
        int n = 0;
        while (rcnt < v && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(rcnt >= v), 64'd1);
    endtask

    task automatic start_txn(input logic [AW-1:0] a, input logic r, input logic [DW-1:0] d,
                             input string tag);
        clear_mon();
        bus.addr    = a;
        bus.rw      = r;
        bus.data_wr = d;
        bus.ena     = 1'b1;
        wait_busy(1'b1, tag);
    endtask

    task automatic finish_txn(input string tag);
        wait_busy(1'b0, tag);
        repeat (4) @(negedge clk);
    endtask

    logic [7:0] rbyte;

    initial begin
        bus.ena     = 1'b0;
        bus.addr    = '0;
        bus.rw      = 1'b0;
        bus.data_wr = '0;
        clear_script();

        // reset state
        repeat (5) @(negedge clk);
        chk("rst_sda",   64'(bus.sda_pull_low), 64'd0);
        chk("rst_scl",   64'(bus.scl_ena),      64'd0);
        chk("rst_busy",  64'(bus.busy),         64'd0);
        chk("rst_rd",    64'(bus.data_rd),      64'd0);
        chk("rst_rdv",   64'(bus.rd_valid),     64'd0);
        chk("rst_ackerr",64'(bus.ack_error),    64'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 1: write 0x50 / 0xA5, both ACKed, single byte
        clear_script();
        slv_script[9]  = 1'b1;
        slv_script[18] = 1'b1;
        start_txn(7'h50, 1'b0, 8'hA5, "t1_busy_up");
        bus.ena = 1'b0;
        finish_txn("t1_busy_dn");
        chk("t1_nbits",  64'(nbits), 64'd19);
        chk("t1_bits",   blog, 64'({8'hA0, 1'b0, 8'hA5, 1'b0, 1'b0}));
        chk("t1_starts", 64'(starts), 64'd1);
        chk("t1_stops",  64'(stops),  64'd1);
        chk("t1_ackerr", 64'(bus.ack_error), 64'd0);
        chk("t1_sda",    64'(bus.sda_pull_low), 64'd0);
        chk("t1_scl",    64'(bus.scl_ena), 64'd0);

        // 2: address NACK
        clear_script();
        start_txn(7'h50, 1'b0, 8'hA5, "t2_busy_up");
        bus.ena = 1'b0;
        finish_txn("t2_busy_dn");
        chk("t2_nbits",  64'(nbits), 64'd10);
        chk("t2_bits",   blog, 64'({8'hA0, 1'b1, 1'b0}));
        chk("t2_ackerr", 64'(bus.ack_error), 64'd1);
        chk("t2_stops",  64'(stops), 64'd1);

        // 3: read 0x3C from 0x50, master NACKs
        clear_script();
        rbyte = 8'h3C;
        slv_script[9] = 1'b1;
        for (int i = 0; i < 8; i++) slv_script[10 + i] = ~rbyte[7 - i];
        start_txn(7'h50, 1'b1, 8'h00, "t3_busy_up");
        bus.ena = 1'b0;
        finish_txn("t3_busy_dn");
        chk("t3_data",   64'(bus.data_rd), 64'h3C);
        chk("t3_rdv",    64'(rdv), 64'd1);
        chk("t3_nbits",  64'(nbits), 64'd19);
        chk("t3_bits",   blog, 64'({8'hA1, 1'b0, 8'h3C, 1'b1, 1'b0}));
        chk("t3_ackerr", 64'(bus.ack_error), 64'd0);
        chk("t3_stops",  64'(stops), 64'd1);

        // 4: two-byte write 0x11, 0x22 with ena held
        clear_script();
        slv_script[9]  = 1'b1;
        slv_script[18] = 1'b1;
        slv_script[27] = 1'b1;
        start_txn(7'h50, 1'b0, 8'h11, "t4_busy_up");
        bus.data_wr = 8'h22;
        wait_rcnt(20, "t4_second_byte");
        bus.ena = 1'b0;
        finish_txn("t4_busy_dn");
        chk("t4_nbits",  64'(nbits), 64'd28);
        chk("t4_bits",   blog, 64'({8'hA0, 1'b0, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0}));
        chk("t4_starts", 64'(starts), 64'd1);
        chk("t4_stops",  64'(stops),  64'd1);
        chk("t4_rdv",    64'(rdv), 64'd0);

        // 5: reset mid-address, then a clean transaction
        clear_script();
        slv_script[9]  = 1'b1;
        slv_script[18] = 1'b1;
        start_txn(7'h50, 1'b0, 8'hA5, "t5_busy_up");
        wait_rcnt(4, "t5_in_addr");
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_sda",  64'(bus.sda_pull_low), 64'd0);
        chk("t5_rst_scl",  64'(bus.scl_ena), 64'd0);
        chk("t5_rst_busy", 64'(bus.busy), 64'd0);
        bus.ena = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        start_txn(7'h50, 1'b0, 8'h5A, "t5b_busy_up");
        bus.ena = 1'b0;
        finish_txn("t5b_busy_dn");
        chk("t5b_nbits",  64'(nbits), 64'd19);
        chk("t5b_bits",   blog, 64'({8'hA0, 1'b0, 8'h5A, 1'b0, 1'b0}));
        chk("t5b_starts", 64'(starts), 64'd1);
        chk("t5b_ackerr", 64'(bus.ack_error), 64'd0);

        // 6: data_clk frozen, ena high: nothing may start
        @(negedge clk);
        dclk_run = 1'b0;
        repeat (3) @(negedge clk);
        clear_mon();
        bus.ena = 1'b1;
        repeat (60) @(negedge clk);
        chk("t6_busy",   64'(bus.busy), 64'd0);
        chk("t6_sda",    64'(bus.sda_pull_low), 64'd0);
        chk("t6_starts", 64'(starts), 64'd0);
        bus.ena = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
